popcount_scheduler: RTL

Serial population-count controller that time-shares one 3-bit chunk counter across a wide input vector. It accepts a WIDTH-bit word over a valid/ready handshake and steps the word through the shared chunk counter, CHUNK bits per cycle. It accumulates the running total and returns the count over a second valid/ready handshake. It is the sequential front end for the bit-counting datapaths, replacing a full-width combinational adder tree with one small counter plus control.

---
 rtl/popcount_pkg.sv | 18 +
 rtl/chunk_popcount.sv | 20 ++
 rtl/popcount_scheduler.sv | 95 +++++++++
 3 files changed

// File: rtl/popcount_pkg.sv
// Shared types and constants for the serial popcount scheduler.
// Holds the FSM state enum, the chunk width and the count-width helper.
package popcount_pkg;

    localparam int CHUNK = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width needed to hold any count from 0 to w inclusive.
    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/chunk_popcount.sv
// Combinational population count of one CHUNK-bit slice.
// This is the single counter that the scheduler time-shares across the word.
module chunk_popcount
    import popcount_pkg::*;
#(
    parameter int N = CHUNK,
    localparam int NW = count_width(N)
) (
    input  logic [N-1:0]  bits_i,
    output logic [NW-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < N; i++) begin
            count_o = count_o + NW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/popcount_scheduler.sv
// Serial popcount: accepts a WIDTH-bit word, counts it CHUNK bits per cycle,
// and returns the total over a valid/ready handshake. Optional macro
// POPCNT_EARLY_EXIT_EN ends the count as soon as the remaining bits are zero.
module popcount_scheduler
    import popcount_pkg::*;
#(
    parameter int WIDTH = 15,
    localparam int CW = count_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             busy
);

    // WIDTH must be a non-zero multiple of CHUNK; NCH is the number of RUN cycles.
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int KW  = count_width(CHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    acc_q, acc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [KW-1:0]    chunk_cnt;

    chunk_popcount #(.N(CHUNK)) u_chunk (
        .bits_i  (sr_q[CHUNK-1:0]),
        .count_o (chunk_cnt)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d    = in_bits;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + CW'(chunk_cnt);
                sr_d  = sr_q >> CHUNK;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
`ifdef POPCNT_EARLY_EXIT_EN
                // Nothing left to count once the shifted word is all zeros.
                if (sr_d == '0) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    // The accumulator is only updated in IDLE-accept and RUN, so it is stable in DONE.
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_count = acc_q;

endmodule
